mac_operand_feeder: RTL

Sequencer that drives the multiply-accumulate compute unit of the convolution datapath. It clears the accumulator, streams `num_terms` operand pairs read from the window/weight buffers into it (one pair per cycle), and holds the operands at zero otherwise. It then captures the finished dot product and presents it downstream on a valid/ready handshake. It is the issuing side of the compute unit's operand interface; the compute unit itself accumulates unconditionally every cycle.

---
 rtl/mac_operand_feeder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mac_operand_feeder.sv
// Operand sequencer for the convolution MAC unit: clears the accumulator, streams
// num_terms buffer pairs into it, then captures and hands off the dot product.
module mac_operand_feeder #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [CNT_WIDTH-1:0]  num_terms,
   output logic                  busy,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data_a,
   input  logic [DATA_WIDTH-1:0] rd_data_b,
   output logic                  mac_rst_n,
   output logic [DATA_WIDTH-1:0] mac_a,
   output logic [DATA_WIDTH-1:0] mac_b,
   input  logic [DATA_WIDTH-1:0] mac_result,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data
);

   // state | meaning
   // IDLE  | waiting for start
   // CLEAR | one cycle, accumulator held in reset
   // FETCH | one buffer read per cycle, num_terms cycles
   // DRAIN | three cycles for the last operands to reach the accumulator
   // OUT   | result presented until out_ready
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_FETCH = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_OUT   = 3'd4;

   localparam logic [CNT_WIDTH-1:0] DRAIN_LAST = CNT_WIDTH'(2);

   logic [2:0]            state_q, state_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  vld_q, vld_d;
   logic                  mac_rst_n_q, mac_rst_n_d;
   logic [DATA_WIDTH-1:0] mac_a_q, mac_a_d;
   logic [DATA_WIDTH-1:0] mac_b_q, mac_b_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      out_data_d = out_data_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               addr_d  = base_addr;
               cnt_d   = num_terms;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            if (cnt_q != '0) begin
               state_d = S_FETCH;
            end else begin
               cnt_d   = DRAIN_LAST;
               state_d = S_DRAIN;
            end
         end
         S_FETCH: begin
            addr_d = addr_q + 1'b1;
            if (cnt_q == CNT_WIDTH'(1)) begin
               cnt_d   = DRAIN_LAST;
               state_d = S_DRAIN;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DRAIN: begin
            // Terminal count: the last product has just landed in the accumulator.
            if (cnt_q == '0) begin
               out_data_d = mac_result;
               state_d    = S_OUT;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_OUT: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Operands are forced to zero whenever no read is returning, so the
   // free-running accumulator only ever adds +0.0 outside a job.
   always_comb begin
      vld_d       = rd_en;
      mac_a_d     = vld_q ? rd_data_a : '0;
      mac_b_d     = vld_q ? rd_data_b : '0;
      mac_rst_n_d = (state_d != S_CLEAR);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         vld_q       <= 1'b0;
         mac_rst_n_q <= 1'b0;
         mac_a_q     <= '0;
         mac_b_q     <= '0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         vld_q       <= vld_d;
         mac_rst_n_q <= mac_rst_n_d;
         mac_a_q     <= mac_a_d;
         mac_b_q     <= mac_b_d;
         out_data_q  <= out_data_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign rd_en     = (state_q == S_FETCH);
   assign rd_addr   = addr_q;
   assign mac_rst_n = mac_rst_n_q;
   assign mac_a     = mac_a_q;
   assign mac_b     = mac_b_q;
   assign out_valid = (state_q == S_OUT);
   assign out_data  = out_data_q;

endmodule
